score_ctrl: RTL and testbench

Score sequencing controller for the Tetris game. It converts line-clear events into points and buffers them while a count-up animation is running. It drives the 8-bit binary score consumed by the two-digit HEX score display, and tracks a high score that alternates with the final score after game over. It sits between the playfield/line-clear logic and the seven-segment display driver.

---
 rtl/score_ctrl_if.sv | 26 ++
 rtl/score_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_score_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_ctrl_if.sv
// score_ctrl_if: bundles the game-event inputs and score/display outputs of
// score_ctrl.
//   master : drives new_game, line_valid, lines, game_over (game logic / bench)
//   slave  : drives score, hi_score, disp_value, disp_alt, busy, state (score_ctrl)
interface score_ctrl_if;
  logic       new_game;
  logic       line_valid;
  logic [2:0] lines;
  logic       game_over;
  logic [7:0] score;
  logic [7:0] hi_score;
  logic [7:0] disp_value;
  logic       disp_alt;
  logic       busy;
  logic [1:0] state;

  modport master (
    output new_game, line_valid, lines, game_over,
    input  score, hi_score, disp_value, disp_alt, busy, state
  );

  modport slave (
    input  new_game, line_valid, lines, game_over,
    output score, hi_score, disp_value, disp_alt, busy, state
  );
endinterface

// File: rtl/score_ctrl.sv
// score_ctrl: converts line-clear events into points, buffers them in a
// saturating pending counter and counts the score up one point per
// STEP_CYCLES. On game over the remaining points are flushed at once, the
// high score is updated, and the display alternates score / high score.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   bus        score_ctrl_if.slave
//                in : new_game, line_valid, lines[2:0], game_over
//                out: score[7:0], hi_score[7:0], disp_value[7:0], disp_alt,
//                     busy, state[1:0] (IDLE=0, PLAY=1, ADD=2, OVER=3)
//
// Build option: define SCORE_HISCORE_EN to build the high-score register and
// the alternating OVER display. Without it hi_score and disp_alt are 0 and
// no alt timer exists.
module score_ctrl #(
  parameter int STEP_CYCLES = 2_500_000,
  parameter int ALT_CYCLES  = 50_000_000,
  parameter int MAX_SCORE   = 99
) (
  input  logic        clk,
  input  logic        rst,
  score_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_ADD  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam int             STW       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STW-1:0] STEP_LAST = STW'(STEP_CYCLES - 1);
  localparam logic [7:0]     MAXV      = 8'(MAX_SCORE);

  // Two-digit display cannot show more than 99.
  generate
    if (MAX_SCORE > 99 || MAX_SCORE < 1 || STEP_CYCLES < 1 || ALT_CYCLES < 1) begin : g_bad_param
      $error("score_ctrl: illegal parameter value");
    end
  endgenerate

  state_t         r_state, w_state;
  logic [7:0]     r_score, w_score;
  logic [4:0]     r_pend,  w_pend;
  logic [STW-1:0] r_step,  w_step;
  logic           r_busy;
  logic [7:0]     r_disp,  w_disp;

  logic [3:0]     w_pts;
  logic [8:0]     w_flush;
  logic [7:0]     w_flush_sat;
  logic [5:0]     w_add_sum;
  logic [5:0]     w_step_sum;

`ifdef SCORE_HISCORE_EN
  localparam int             ATW      = (ALT_CYCLES > 1) ? $clog2(ALT_CYCLES) : 1;
  localparam logic [ATW-1:0] ALT_LAST = ATW'(ALT_CYCLES - 1);
  logic [7:0]     r_hi,   w_hi;
  logic           r_alt,  w_alt;
  logic [ATW-1:0] r_atmr, w_atmr;
`endif

  function automatic logic [4:0] sat5(input logic [5:0] v);
    return (v > 6'd31) ? 5'd31 : v[4:0];
  endfunction

  // Points of this cycle's event; zero means "no valid event".
  always_comb begin
    w_pts = 4'd0;
    if (bus.line_valid) begin
      case (bus.lines)
        3'd1:    w_pts = 4'd1;
        3'd2:    w_pts = 4'd3;
        3'd3:    w_pts = 4'd5;
        3'd4:    w_pts = 4'd8;
        default: w_pts = 4'd0;
      endcase
    end
  end

  // Worst case 99 + 31 + 8 fits in 9 bits before saturation.
  assign w_flush     = {1'b0, r_score} + {4'b0, r_pend} + {5'b0, w_pts};
  assign w_flush_sat = (w_flush > {1'b0, MAXV}) ? MAXV : w_flush[7:0];
  assign w_add_sum   = {1'b0, r_pend} + {2'b0, w_pts};
  // Only used in ADD, where pending is at least 1.
  assign w_step_sum  = w_add_sum - 6'd1;

  always_comb begin
    w_state = r_state;
    w_score = r_score;
    w_pend  = r_pend;
    w_step  = r_step;
`ifdef SCORE_HISCORE_EN
    w_hi    = r_hi;
    w_alt   = r_alt;
    w_atmr  = r_atmr;
`endif
    if (bus.new_game) begin
      w_state = S_PLAY;
      w_score = 8'd0;
      w_pend  = 5'd0;
      w_step  = '0;
`ifdef SCORE_HISCORE_EN
      w_alt   = 1'b0;
      w_atmr  = '0;
`endif
    end else begin
      case (r_state)
        S_PLAY, S_ADD: begin
          if (bus.game_over) begin
            w_state = S_OVER;
            w_score = w_flush_sat;
            w_pend  = 5'd0;
            w_step  = '0;
`ifdef SCORE_HISCORE_EN
            w_alt   = 1'b0;
            w_atmr  = '0;
            if (w_flush_sat > r_hi) w_hi = w_flush_sat;
`endif
          end else if (r_state == S_PLAY) begin
            // A saturated score discards further events.
            if (w_pts != 4'd0 && r_score != MAXV) begin
              w_state = S_ADD;
              w_pend  = {1'b0, w_pts};
              w_step  = '0;
            end
          end else if (r_step == STEP_LAST) begin
            w_step  = '0;
            w_score = r_score + 8'd1;
            w_pend  = sat5(w_step_sum);
            if (r_score + 8'd1 == MAXV) begin
              w_pend  = 5'd0;
              w_state = S_PLAY;
            end else if (sat5(w_step_sum) == 5'd0) begin
              w_state = S_PLAY;
            end
          end else begin
            w_step = r_step + 1'b1;
            w_pend = sat5(w_add_sum);
          end
        end
        S_OVER: begin
`ifdef SCORE_HISCORE_EN
          if (r_atmr == ALT_LAST) begin
            w_atmr = '0;
            w_alt  = ~r_alt;
          end else begin
            w_atmr = r_atmr + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_HISCORE_EN
  assign w_disp = w_alt ? w_hi : w_score;
`else
  assign w_disp = w_score;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_score <= 8'd0;
      r_pend  <= 5'd0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_disp  <= 8'd0;
`ifdef SCORE_HISCORE_EN
      r_hi    <= 8'd0;
      r_alt   <= 1'b0;
      r_atmr  <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_score <= w_score;
      r_pend  <= w_pend;
      r_step  <= w_step;
      r_busy  <= (w_state == S_ADD);
      r_disp  <= w_disp;
`ifdef SCORE_HISCORE_EN
      r_hi    <= w_hi;
      r_alt   <= w_alt;
      r_atmr  <= w_atmr;
`endif
    end
  end

  assign bus.score      = r_score;
  assign bus.disp_value = r_disp;
  assign bus.busy       = r_busy;
  assign bus.state      = r_state;
`ifdef SCORE_HISCORE_EN
  assign bus.hi_score   = r_hi;
  assign bus.disp_alt   = r_alt;
`else
  assign bus.hi_score   = 8'd0;
  assign bus.disp_alt   = 1'b0;
`endif

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed table and sequences plus random stimulus,
// every cycle compared against a cycle-accurate reference model that works
// from absolute cycle numbers (due time of the next step, OVER entry time).
module tb_score_ctrl;
  localparam int STEP = 4;
  localparam int ALT  = 8;
  localparam int MAXS = 99;
`ifdef SCORE_HISCORE_EN
  localparam bit HIEN = 1'b1;
`else
  localparam bit HIEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_ctrl_if bus ();

  score_ctrl #(.STEP_CYCLES(STEP), .ALT_CYCLES(ALT), .MAX_SCORE(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state.
  int m_st = 0, m_score = 0, m_pend = 0, m_hi = 0, m_due = 0, m_over = 0;
  int ptab [5] = '{0, 1, 3, 5, 8};

  typedef struct {
    logic       ng;
    logic       lv;
    logic [2:0] ln;
    int         st;
    int         sc;
    int         bz;
  } vec_t;
  vec_t tbl [10];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flush(input int pts);
    m_score = imin(m_score + m_pend + pts, MAXS);
    m_pend  = 0;
    m_st    = 3;
    m_over  = cyc;
    if (HIEN && m_score > m_hi) m_hi = m_score;
  endtask

  task automatic model(input logic r, input logic ng, input logic lv,
                       input logic [2:0] ln, input logic go);
    int pts;
    pts = (lv && ln >= 3'd1 && ln <= 3'd4) ? ptab[int'(ln)] : 0;
    if (r) begin
      m_st = 0; m_score = 0; m_pend = 0; m_hi = 0;
    end else if (ng) begin
      m_st = 1; m_score = 0; m_pend = 0;
    end else if (m_st == 1) begin
      if (go) flush(pts);
      else if (pts > 0 && m_score < MAXS) begin
        m_pend = imin(pts, 31);
        m_st   = 2;
        m_due  = cyc + STEP;
      end
    end else if (m_st == 2) begin
      if (go) flush(pts);
      else if (cyc == m_due) begin
        m_score++;
        m_pend = imin(m_pend - 1 + pts, 31);
        m_due  = cyc + STEP;
        if (m_score == MAXS) begin
          m_pend = 0;
          m_st   = 1;
        end else if (m_pend == 0) m_st = 1;
      end else m_pend = imin(m_pend + pts, 31);
    end
  endtask

  task automatic check_model();
    int e_alt, e_disp;
    e_alt = 0;
    if (HIEN && m_st == 3) e_alt = ((cyc - m_over) / ALT) % 2;
    e_disp = (e_alt != 0) ? m_hi : m_score;
    checks++;
    if (bus.state !== 2'(m_st) || bus.score !== 8'(m_score) || bus.hi_score !== 8'(m_hi) ||
        bus.disp_value !== 8'(e_disp) || bus.disp_alt !== 1'(e_alt) || bus.busy !== (m_st == 2)) begin
      errors++;
      $display("FAIL model cyc=%0d got st=%0d sc=%0d hi=%0d dv=%0d alt=%0d busy=%0d expected st=%0d sc=%0d hi=%0d dv=%0d alt=%0d busy=%0d",
               cyc, bus.state, bus.score, bus.hi_score, bus.disp_value, bus.disp_alt, bus.busy,
               m_st, m_score, m_hi, e_disp, e_alt, (m_st == 2));
    end
  endtask

  // One clock: drive, edge, update model, sample 1 time unit later.
  task automatic step(input logic r, input logic ng, input logic lv,
                      input logic [2:0] ln, input logic go);
    rst            = r;
    bus.new_game   = ng;
    bus.line_valid = lv;
    bus.lines      = ln;
    bus.game_over  = go;
    @(posedge clk);
    cyc++;
    model(r, ng, lv, ln, go);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  // Event in PLAY, then wait until all its points have been counted.
  task automatic add_evt(input logic [2:0] ln, input int pts);
    step(1'b0, 1'b0, 1'b1, ln, 1'b0);
    idle(pts * STEP);
  endtask

  // Ends with score 17 in OVER: ADD with score 10 / pending 6, then
  // game_over together with a 1-line event.
  task automatic mk17();
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    add_evt(3'd4, 8);
    step(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    idle(4);
    chk("pre17_score", bus.score, 10);
    step(1'b0, 1'b0, 1'b1, 3'd1, 1'b1);
    chk("flush_score", bus.score, 17);
    chk("flush_state", bus.state, 3);
    chk("flush_busy",  bus.busy, 0);
  endtask

  initial begin
    logic r, ng, lv, go;
    logic [2:0] ln;

    // Reset
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("rst_score", bus.score, 0);
    chk("rst_hi",    bus.hi_score, 0);
    chk("rst_disp",  bus.disp_value, 0);
    chk("rst_alt",   bus.disp_alt, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_state", bus.state, 0);

    // 4-line clear counted up one point per STEP cycles; invalid line counts ignored.
    tbl[0] = '{1'b1, 1'b0, 3'd0, 1, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 3'd4, 2, 0, 1};
    tbl[2] = '{1'b0, 1'b0, 3'd0, 2, 0, 1};
    tbl[3] = '{1'b0, 1'b0, 3'd0, 2, 0, 1};
    tbl[4] = '{1'b0, 1'b0, 3'd0, 2, 0, 1};
    tbl[5] = '{1'b0, 1'b0, 3'd0, 2, 1, 1};
    tbl[6] = '{1'b0, 1'b1, 3'd0, 2, 1, 1};
    tbl[7] = '{1'b0, 1'b1, 3'd5, 2, 1, 1};
    tbl[8] = '{1'b0, 1'b0, 3'd0, 2, 1, 1};
    tbl[9] = '{1'b0, 1'b0, 3'd0, 2, 2, 1};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].ng, tbl[i].lv, tbl[i].ln, 1'b0);
      chk($sformatf("tbl%0d_state", i), bus.state, tbl[i].st);
      chk($sformatf("tbl%0d_score", i), bus.score, tbl[i].sc);
      chk($sformatf("tbl%0d_busy", i),  bus.busy,  tbl[i].bz);
    end
    idle(23);
    chk("t1_score7", bus.score, 7);
    chk("t1_add",    bus.state, 2);
    idle(1);
    chk("t1_score8", bus.score, 8);
    chk("t1_play",   bus.state, 1);
    chk("t1_busy0",  bus.busy, 0);

    // Event coincident with a step: pending 3-1+3, total gain 6.
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    chk("t2_first", bus.score, 1);
    idle(19);
    chk("t2_score5", bus.score, 5);
    chk("t2_add",    bus.state, 2);
    idle(1);
    chk("t2_score6", bus.score, 6);
    chk("t2_play",   bus.state, 1);

    // Flush on game_over with coincident event.
    mk17();
    chk("t4_hi", bus.hi_score, HIEN ? 17 : 0);

    // Build high score 40, then score 17 in OVER and watch the alternation.
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (5) add_evt(3'd4, 8);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("t5_hi40", bus.hi_score, HIEN ? 40 : 0);
    mk17();
    chk("t5_hi_kept", bus.hi_score, HIEN ? 40 : 0);
    idle(7);
    chk("alt_e7_disp", bus.disp_value, 17);
    chk("alt_e7_alt",  bus.disp_alt, 0);
    idle(1);
    chk("alt_e8_disp", bus.disp_value, HIEN ? 40 : 17);
    chk("alt_e8_alt",  bus.disp_alt, HIEN ? 1 : 0);
    idle(8);
    chk("alt_e16_disp", bus.disp_value, 17);
    chk("alt_e16_alt",  bus.disp_alt, 0);

    // Saturation at MAX_SCORE.
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (12) add_evt(3'd4, 8);
    add_evt(3'd1, 1);
    chk("t3_97", bus.score, 97);
    step(1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
    idle(8);
    chk("t3_sat_score", bus.score, 99);
    chk("t3_sat_state", bus.state, 1);
    chk("t3_sat_busy",  bus.busy, 0);
    step(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    chk("t3_disc_state", bus.state, 1);
    chk("t3_disc_score", bus.score, 99);

    // new_game beats game_over mid-ADD; pending is cleared; then reset.
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    chk("t6_state", bus.state, 1);
    chk("t6_score", bus.score, 0);
    chk("t6_busy",  bus.busy, 0);
    chk("t6_hi",    bus.hi_score, HIEN ? 40 : 0);
    step(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    idle(4);
    chk("t6_pend_clr_score", bus.score, 1);
    chk("t6_pend_clr_state", bus.state, 1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("t6_rst_state", bus.state, 0);
    chk("t6_rst_hi",    bus.hi_score, 0);
    chk("t6_rst_score", bus.score, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 999) == 0);
      ng = ($urandom_range(0, 49) == 0);
      go = ($urandom_range(0, 69) == 0);
      lv = ($urandom_range(0, 4) == 0);
      ln = 3'($urandom_range(0, 7));
      step(r, ng, lv, ln, go);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
